// File: rtl/pixel_canvas_brush_if.sv
// pixel_canvas_brush_if -- request/read bus of the pixel canvas brush.
//   rx/ry/color_code       : synchronous read port (1-cycle latency)
//   brush/wx/wy/radius/new_color : square brush stroke request
//   clear                  : full-screen clear request
//   ready                  : engine idle, request accepted this cycle
//   write_count            : pixel-write counter (only with PIXEL_CANVAS_WRITE_CNT_EN)
// master = requester/display side, slave = the canvas.
interface pixel_canvas_brush_if #(
  parameter int XW = 3,
  parameter int YW = 3,
  parameter int CB = 3,
  parameter int RW = 2
);
  logic [XW-1:0] rx;
  logic [YW-1:0] ry;
  logic [CB-1:0] color_code;
  logic          brush;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  logic [RW-1:0] radius;
  logic [CB-1:0] new_color;
  logic          clear;
  logic          ready;
`ifdef PIXEL_CANVAS_WRITE_CNT_EN
  logic [15:0]   write_count;
`endif

  modport master (
    output rx, ry, brush, wx, wy, radius, new_color, clear,
    input  color_code, ready
`ifdef PIXEL_CANVAS_WRITE_CNT_EN
    , input write_count
`endif
  );

  modport slave (
    input  rx, ry, brush, wx, wy, radius, new_color, clear,
    output color_code, ready
`ifdef PIXEL_CANVAS_WRITE_CNT_EN
    , output write_count
`endif
  );
endinterface

// File: rtl/pixel_canvas_brush.sv
// pixel_canvas_brush -- WIDTH x HEIGHT framebuffer of COLOR_BITS colour codes.
// A small FSM paints square brush strokes (side 2r+1, one candidate pixel per
// cycle, row-major, off-canvas pixels skipped but timed) and full-screen
// clears (one pixel per cycle). The read port is live in every state.
// Ports:
//   clk   : system clock, posedge
//   reset : asynchronous, active-low; array contents are not reset
//   bus   : pixel_canvas_brush_if.slave (read port, requests, ready)
// Optional: define PIXEL_CANVAS_WRITE_CNT_EN to add bus.write_count, a
// saturating 16-bit count of actual pixel writes.
module pixel_canvas_brush #(
  parameter int          WIDTH       = 8,
  parameter int          HEIGHT      = 8,
  parameter int          COLOR_BITS  = 3,
  parameter int          MAX_RADIUS  = 3,
  parameter int unsigned CLEAR_COLOR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_canvas_brush_if.slave  bus
);
  localparam int XW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int RW  = (MAX_RADIUS > 0) ? $clog2(MAX_RADIUS + 1) : 1;
  // Target arithmetic is wide enough that centre+offset never wraps back
  // into the canvas; negatives become huge unsigned and fail the < bound.
  localparam int TXW = ((XW > RW) ? XW : RW) + 2;
  localparam int TYW = ((YW > RW) ? YW : RW) + 2;

  typedef enum logic [1:0] {S_IDLE, S_PAINT, S_CLEAR} state_t;

  state_t state_q, state_d;

  logic [COLOR_BITS-1:0] mem [HEIGHT][WIDTH];
  logic [COLOR_BITS-1:0] color_q;

  // cx_q/cy_q hold the stroke centre in PAINT and the sweep index in CLEAR
  logic [XW-1:0]         cx_q;
  logic [YW-1:0]         cy_q;
  logic [RW-1:0]         r_q;
  logic [COLOR_BITS-1:0] col_q;
  logic signed [RW:0]    dx_q, dy_q;

  logic [RW-1:0]         r_clamp;
  logic signed [RW:0]    rin_s, r_s;
  logic [TXW-1:0]        tx;
  logic [TYW-1:0]        ty;
  logic                  last_off, last_px;

  logic                  we;
  logic [XW-1:0]         wa_x;
  logic [YW-1:0]         wa_y;
  logic [COLOR_BITS-1:0] wd;

  assign r_clamp = (bus.radius > RW'(MAX_RADIUS)) ? RW'(MAX_RADIUS) : bus.radius;
  assign rin_s   = $signed({1'b0, r_clamp});
  assign r_s     = $signed({1'b0, r_q});

  assign tx = {{(TXW-XW){1'b0}}, cx_q} + {{(TXW-RW-1){dx_q[RW]}}, dx_q};
  assign ty = {{(TYW-YW){1'b0}}, cy_q} + {{(TYW-RW-1){dy_q[RW]}}, dy_q};

  assign last_off = (dx_q == r_s) && (dy_q == r_s);
  assign last_px  = (cx_q == XW'(WIDTH - 1)) && (cy_q == YW'(HEIGHT - 1));

  assign bus.ready      = (state_q == S_IDLE);
  assign bus.color_code = color_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clear)      state_d = S_CLEAR;
        else if (bus.brush) state_d = S_PAINT;
      end
      S_PAINT: if (last_off) state_d = S_IDLE;
      S_CLEAR: if (last_px)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx_q  <= '0;
      cy_q  <= '0;
      r_q   <= '0;
      col_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.clear) begin
            cx_q <= '0;
            cy_q <= '0;
          end else if (bus.brush) begin
            cx_q  <= bus.wx;
            cy_q  <= bus.wy;
            r_q   <= r_clamp;
            col_q <= bus.new_color;
            dx_q  <= -rin_s;
            dy_q  <= -rin_s;
          end
        end
        S_PAINT: begin
          if (dx_q == r_s) begin
            dx_q <= -r_s;
            dy_q <= dy_q + (RW+1)'(1);
          end else begin
            dx_q <= dx_q + (RW+1)'(1);
          end
        end
        S_CLEAR: begin
          if (cx_q == XW'(WIDTH - 1)) begin
            cx_q <= '0;
            cy_q <= cy_q + YW'(1);
          end else begin
            cx_q <= cx_q + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    we   = 1'b0;
    wa_x = cx_q;
    wa_y = cy_q;
    wd   = col_q;
    unique case (state_q)
      S_PAINT: begin
        we   = (tx < TXW'(WIDTH)) && (ty < TYW'(HEIGHT));
        wa_x = tx[XW-1:0];
        wa_y = ty[YW-1:0];
      end
      S_CLEAR: begin
        we = 1'b1;
        wd = COLOR_BITS'(CLEAR_COLOR);
      end
      default: ;
    endcase
  end

  // Non-blocking read and write on the same edge give read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[wa_y][wa_x] <= wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      color_q <= '0;
    else if (({1'b0, bus.rx} < (XW+1)'(WIDTH)) && ({1'b0, bus.ry} < (YW+1)'(HEIGHT)))
      color_q <= mem[bus.ry][bus.rx];
    else
      color_q <= '0;
  end

`ifdef PIXEL_CANVAS_WRITE_CNT_EN
  logic [15:0] wcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  wcnt_q <= '0;
    else if (we && wcnt_q != '1) wcnt_q <= wcnt_q + 16'd1;
  end

  assign bus.write_count = wcnt_q;
`endif

endmodule

// File: tb/tb_pixel_canvas_brush.sv
// tb_pixel_canvas_brush -- randomized self-checking bench for pixel_canvas_brush.
// Reference model: a plain 2-D int array updated per stroke/clear from the
// geometric rule, plus a count of in-canvas writes.
module tb_pixel_canvas_brush;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CB = 3;
  localparam int MR = 3;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int RW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_canvas_brush_if #(.XW(XW), .YW(YW), .CB(CB), .RW(RW)) bus ();

  pixel_canvas_brush #(
    .WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB), .MAX_RADIUS(MR), .CLEAR_COLOR(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int model [H][W];
  int model_writes = 0;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wcnt(input string tag);
`ifdef PIXEL_CANVAS_WRITE_CNT_EN
    check(tag, int'(bus.write_count), (model_writes > 65535) ? 65535 : model_writes);
`endif
  endtask

  // Counts busy cycles while throwing random junk at every request input,
  // all of which must be ignored.
  task automatic wait_idle(output int n);
    n = 0;
    while (!bus.ready && n < 200) begin
      bus.brush     = 1'($urandom_range(0, 1));
      bus.clear     = 1'($urandom_range(0, 1));
      bus.wx        = XW'($urandom_range(0, W - 1));
      bus.wy        = YW'($urandom_range(0, H - 1));
      bus.radius    = RW'($urandom_range(0, 3));
      bus.new_color = CB'($urandom_range(0, 7));
      bus.rx        = XW'($urandom_range(0, W - 1));
      bus.ry        = YW'($urandom_range(0, H - 1));
      n++;
      step();
    end
    bus.brush = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic check_pixel(input int x, input int y, input string tag);
    bus.rx = XW'(x);
    bus.ry = YW'(y);
    step();
    check(tag, int'(bus.color_code), model[y][x]);
  endtask

  task automatic check_all(input string tag);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        check_pixel(x, y, tag);
  endtask

  task automatic model_stroke(input int cx, input int cy, input int r, input int c, input int limit);
    int k;
    k = 0;
    for (int dy = -r; dy <= r; dy++)
      for (int dx = -r; dx <= r; dx++) begin
        if (k < limit && cx + dx >= 0 && cx + dx < W && cy + dy >= 0 && cy + dy < H) begin
          model[cy + dy][cx + dx] = c;
          model_writes++;
        end
        k++;
      end
  endtask

  task automatic paint(input int x, input int y, input int r, input int c, input string tag);
    int n, rc;
    rc = (r > MR) ? MR : r;
    bus.wx        = XW'(x);
    bus.wy        = YW'(y);
    bus.radius    = RW'(r);
    bus.new_color = CB'(c);
    bus.brush     = 1'b1;
    bus.clear     = 1'b0;
    step();
    wait_idle(n);
    check({tag, "_busy"}, n, (2 * rc + 1) * (2 * rc + 1));
    model_stroke(x, y, rc, c, 1000);
    check_wcnt({tag, "_wcnt"});
  endtask

  task automatic do_clear(input bit with_brush, input string tag);
    int n;
    bus.clear     = 1'b1;
    bus.brush     = with_brush;
    bus.wx        = XW'($urandom_range(0, W - 1));
    bus.wy        = YW'($urandom_range(0, H - 1));
    bus.radius    = RW'($urandom_range(0, 3));
    bus.new_color = CB'($urandom_range(1, 7));
    step();
    wait_idle(n);
    check({tag, "_busy"}, n, W * H);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        model[y][x] = 0;
    model_writes += W * H;
    check_wcnt({tag, "_wcnt"});
  endtask

  initial begin
    reset         = 1'b0;
    bus.rx        = '0;
    bus.ry        = '0;
    bus.brush     = 1'b0;
    bus.wx        = '0;
    bus.wy        = '0;
    bus.radius    = '0;
    bus.new_color = '0;
    bus.clear     = 1'b0;
    repeat (3) step();
    check("rst_ready", int'(bus.ready), 1);
    check("rst_color", int'(bus.color_code), 0);
    check_wcnt("rst_wcnt");
    reset = 1'b1;
    step();

    // clear and brush together: clear wins, brush never runs
    do_clear(1'b1, "clr_prio");
    check("clr_ready", int'(bus.ready), 1);
    check_all("clr_all");

    // single pixel, with read-before-write on the written address
    bus.wx = 3'd2; bus.wy = 3'd4; bus.radius = 2'd0; bus.new_color = 3'b101;
    bus.rx = 3'd2; bus.ry = 3'd4; bus.brush = 1'b1;
    step();
    bus.brush = 1'b0;
    check("px_busy", int'(bus.ready), 0);
    check("px_old", int'(bus.color_code), model[4][2]);
    step();
    check("px_ready", int'(bus.ready), 1);
    check("px_rbw", int'(bus.color_code), model[4][2]);
    step();
    model[4][2] = 5;
    model_writes++;
    check("px_new", int'(bus.color_code), 5);
    check_wcnt("px_wcnt");
    check_all("px_all");

    paint(4, 4, 1, 3, "full");
    check_all("full_all");

    paint(0, 0, 2, 7, "corner");
    check_all("corner_all");

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0)
        do_clear(1'($urandom_range(0, 1)), "rnd_clr");
      else
        paint($urandom_range(0, W - 1), $urandom_range(0, H - 1),
              $urandom_range(0, 3), $urandom_range(0, 7), "rnd");
      for (int k = 0; k < 3; k++)
        check_pixel($urandom_range(0, W - 1), $urandom_range(0, H - 1), "rnd_px");
    end
    check_all("rnd_all");

    // reset four writes into an r=1 stroke
    bus.wx = 3'd3; bus.wy = 3'd3; bus.radius = 2'd1;
    bus.new_color = CB'((model[2][2] + 1) % 8);
    bus.brush = 1'b1;
    step();
    bus.brush = 1'b0;
    model_stroke(3, 3, 1, int'(bus.new_color), 4);
    repeat (4) step();
    reset = 1'b0;
    #1;
    check("abort_ready", int'(bus.ready), 1);
    check("abort_color", int'(bus.color_code), 0);
    model_writes = 0;
    check_wcnt("abort_wcnt");
    step();
    step();
    reset = 1'b1;
    step();
    check_all("abort_all");
    check_wcnt("abort_wcnt2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
